// File: rtl/clock_chain_ctrl.sv
// Seconds/minutes/hours cascade with a button-driven time-set state machine.
// Optional display blink strobe in set modes: define CLOCK_CHAIN_BLINK_EN.
module clock_chain_ctrl #(
  parameter int unsigned SEC_MOD = 60,
  parameter int unsigned MIN_MOD = 60,
  parameter int unsigned HR_MOD  = 24,
  parameter int unsigned SW      = 6,
  parameter int unsigned HW      = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          btn_mode,
  input  logic          btn_up,
  input  logic          btn_down,
  output logic [SW-1:0] sec,
  output logic [SW-1:0] min,
  output logic [HW-1:0] hr,
  output logic [1:0]    mode,
  output logic          day_wrap,
  output logic          blink
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam logic [SW-1:0] SEC_MAX = SW'(SEC_MOD - 1);
  localparam logic [SW-1:0] MIN_MAX = SW'(MIN_MOD - 1);
  localparam logic [HW-1:0] HR_MAX  = HW'(HR_MOD - 1);

  state_t state;
  logic   step_up;
  logic   step_down;

  // A mode press suppresses up/down; pressing both together cancels out.
  assign step_up   = btn_up & ~btn_down & ~btn_mode;
  assign step_down = btn_down & ~btn_up & ~btn_mode;
  assign mode      = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      sec      <= '0;
      min      <= '0;
      hr       <= '0;
      day_wrap <= 1'b0;
    end else begin
      day_wrap <= 1'b0;
      case (state)
        RUN: begin
          if (tick) begin
            if (sec == SEC_MAX) begin
              sec <= '0;
              if (min == MIN_MAX) begin
                min <= '0;
                if (hr == HR_MAX) begin
                  hr       <= '0;
                  day_wrap <= 1'b1;
                end else begin
                  hr <= hr + 1'b1;
                end
              end else begin
                min <= min + 1'b1;
              end
            end else begin
              sec <= sec + 1'b1;
            end
          end
          if (btn_mode) state <= SET_HR;
        end
        SET_HR: begin
          if (btn_mode)       state <= SET_MIN;
          else if (step_up)   hr <= (hr == HR_MAX) ? '0 : hr + 1'b1;
          else if (step_down) hr <= (hr == '0) ? HR_MAX : hr - 1'b1;
        end
        SET_MIN: begin
          if (btn_mode) begin
            state <= RUN;
            sec   <= '0;
          end else if (step_up) begin
            min <= (min == MIN_MAX) ? '0 : min + 1'b1;
          end else if (step_down) begin
            min <= (min == '0) ? MIN_MAX : min - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef CLOCK_CHAIN_BLINK_EN
  // Any mode press lands in a fresh mode, so blink restarts from 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink <= 1'b0;
    end else if ((state == SET_HR || state == SET_MIN) && !btn_mode) begin
      if (tick) blink <= ~blink;
    end else begin
      blink <= 1'b0;
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule
